multi_channel_wave_source: RTL and testbench

//  Parametrised, clocked successor to the fixed-amplitude AC stimulus sources. Provides NCH

---
 rtl/multi_channel_wave_source_if.sv | 30 +++
 rtl/multi_channel_wave_source.sv | 190 +++++++++++++++++++
 tb/tb_multi_channel_wave_source.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_wave_source_if.sv
// Control, configuration and sample bus of the multi-channel periodic wave source.
// The master drives the strobes and config writes; the slave returns samples and status.
interface multi_channel_wave_source_if #(
  parameter int NCH   = 2,
  parameter int OUT_W = 16
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   tick;
  logic                   sync;
  logic                   cfg_we;
  logic [CW-1:0]          cfg_ch;
  logic [2:0]             cfg_addr;
  logic [31:0]            cfg_wdata;
  logic                   cfg_err;
  logic                   commit;
  logic                   commit_pend;
  logic                   out_valid;
  logic [NCH*OUT_W-1:0]   out_data;

  modport master (
    output tick, sync, cfg_we, cfg_ch, cfg_addr, cfg_wdata, commit,
    input  cfg_err, commit_pend, out_valid, out_data
  );

  modport slave (
    input  tick, sync, cfg_we, cfg_ch, cfg_addr, cfg_wdata, commit,
    output cfg_err, commit_pend, out_valid, out_data
  );
endinterface

// File: rtl/multi_channel_wave_source.sv
// NCH independent phase-accumulator wave sources with shadow/active config banks.
// Each sample set appears two clocks after its tick; PHASE_W and OUT_W must not exceed 32.
module multi_channel_wave_source_lane #(
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 12,
  parameter int OUT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [2:0]       i_addr,
  input  logic [31:0]      i_wdata,
  input  logic             i_apply,
  input  logic             i_adv,
  input  logic             i_sync,
  input  logic             i_sample,
  output logic [OUT_W-1:0] o_data
);
  localparam int SW = OUT_W + 2;
  localparam logic signed [AMP_W-1:0] W_MAX = {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic signed [SW-1:0]    Y_MAX = SW'(2**(OUT_W-1) - 1);
  localparam logic signed [SW-1:0]    Y_MIN = SW'(-(2**(OUT_W-1)));

  typedef struct packed {
    logic [PHASE_W-1:0]      freq;
    logic [PHASE_W-1:0]      phase;
    logic [AMP_W-1:0]        amp;
    logic signed [OUT_W-1:0] offset;
    logic                    en;
    logic [1:0]              mode;
  } cfg_t;

  cfg_t                      r_shadow, r_active, w_cfg;
  logic [PHASE_W-1:0]        r_acc;
  logic [OUT_W-1:0]          r_out;
  logic [PHASE_W-1:0]        w_p;
  logic [PHASE_W+AMP_W-1:0]  w_pz;
  logic [AMP_W-1:0]          w_t;
  logic [AMP_W-2:0]          w_u;
  logic signed [AMP_W-1:0]   w_w;
  logic signed [2*AMP_W:0]   w_prod, w_scl;
  logic signed [SW-1:0]      w_sum;
  logic [OUT_W-1:0]          w_sat;
  logic                      w_unused;

  assign w_unused = ^{i_wdata, w_pz};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= '0;
    end else if (i_we) begin
      case (i_addr)
        3'd0: r_shadow.freq   <= i_wdata[PHASE_W-1:0];
        3'd1: r_shadow.phase  <= i_wdata[PHASE_W-1:0];
        3'd2: r_shadow.amp    <= i_wdata[AMP_W-1:0];
        3'd3: r_shadow.offset <= i_wdata[OUT_W-1:0];
        3'd4: begin
          r_shadow.mode <= i_wdata[1:0];
          r_shadow.en   <= i_wdata[4];
        end
        default: ;
      endcase
    end
  end

  // the apply tick already accumulates with the freshly committed bank
  assign w_cfg = i_apply ? r_shadow : r_active;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_active <= '0;
      r_acc    <= '0;
    end else begin
      if (i_apply) r_active <= r_shadow;
      if (i_sync)
        r_acc <= '0;
      else if (i_adv && w_cfg.en)
        r_acc <= r_acc + w_cfg.freq;
    end
  end

  assign w_p  = r_acc + r_active.phase;
  assign w_pz = {w_p, {AMP_W{1'b0}}};
  assign w_t  = w_pz[PHASE_W+AMP_W-1 -: AMP_W];
  assign w_u  = w_t[AMP_W-1] ? ~w_t[AMP_W-2:0] : w_t[AMP_W-2:0];

  always_comb begin
    w_w = W_MAX;
    case (r_active.mode)
      2'd1:    w_w = w_p[PHASE_W-1] ? -W_MAX : W_MAX;
      2'd2:    w_w = w_t ^ {1'b1, {(AMP_W-1){1'b0}}};
      2'd3:    w_w = {w_u, 1'b0} - W_MAX;
      default: ;
    endcase
  end

  assign w_prod = w_w * $signed({1'b0, r_active.amp});
  assign w_scl  = w_prod >>> AMP_W;
  assign w_sum  = SW'($signed(r_active.offset)) + SW'(w_scl);

  always_comb begin
    w_sat = OUT_W'(w_sum);
    if (w_sum > Y_MAX)
      w_sat = OUT_W'(Y_MAX);
    else if (w_sum < Y_MIN)
      w_sat = OUT_W'(Y_MIN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      r_out <= '0;
    else if (i_sample)
      r_out <= r_active.en ? w_sat : r_active.offset;
  end

  assign o_data = r_out;
endmodule

module multi_channel_wave_source #(
  parameter int NCH     = 2,
  parameter int PHASE_W = 24,
  parameter int AMP_W   = 12,
  parameter int OUT_W   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  multi_channel_wave_source_if.slave    io_bus
);
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int STAGES = 2;

  logic [STAGES:1]             r_vld_pipe;
  logic                        r_commit_pend;
  logic                        r_cfg_err;
  logic                        w_apply;
  logic                        w_bad;
  logic                        w_ch_oob;
  logic [NCH-1:0]              w_lane_we;
  logic [NCH-1:0][OUT_W-1:0]   w_lane_out;

  // only a non-power-of-two channel count leaves unused channel codes
  generate
    if ((1 << CW) > NCH) begin : g_oob
      assign w_ch_oob = 32'(io_bus.cfg_ch) >= NCH;
    end else begin : g_no_oob
      assign w_ch_oob = 1'b0;
    end
  endgenerate

  assign w_bad   = (io_bus.cfg_addr > 3'd4) | w_ch_oob;
  assign w_apply = io_bus.tick & (io_bus.commit | r_commit_pend);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe    <= '0;
      r_commit_pend <= 1'b0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[STAGES-1:1], io_bus.tick};
      r_commit_pend <= ~w_apply & (io_bus.commit | r_commit_pend);
      r_cfg_err     <= io_bus.cfg_we & w_bad;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign w_lane_we[k] = io_bus.cfg_we & ~w_bad & (io_bus.cfg_ch == CW'(k));

    multi_channel_wave_source_lane #(
      .PHASE_W (PHASE_W),
      .AMP_W   (AMP_W),
      .OUT_W   (OUT_W)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_we     (w_lane_we[k]),
      .i_addr   (io_bus.cfg_addr),
      .i_wdata  (io_bus.cfg_wdata),
      .i_apply  (w_apply),
      .i_adv    (io_bus.tick),
      .i_sync   (io_bus.sync),
      .i_sample (r_vld_pipe[1]),
      .o_data   (w_lane_out[k])
    );
  end

  assign io_bus.out_data    = w_lane_out;
  assign io_bus.out_valid   = r_vld_pipe[STAGES];
  assign io_bus.commit_pend = r_commit_pend;
  assign io_bus.cfg_err     = r_cfg_err;
endmodule

// File: tb/tb_multi_channel_wave_source.sv
// Randomised and directed bench for multi_channel_wave_source with a queue scoreboard
// fed by an arithmetic reference model of the channel sources.
module tb_multi_channel_wave_source;
  localparam int NCH = 2, PW = 8, AW = 8, OW = 10;
  localparam int CW  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multi_channel_wave_source_if #(.NCH(NCH), .OUT_W(OW)) bus();

  multi_channel_wave_source #(
    .NCH(NCH), .PHASE_W(PW), .AMP_W(AW), .OUT_W(OW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.slave)
  );

  typedef struct { int freq; int phase; int amp; int offset; int mode; bit en; } mcfg_t;
  typedef struct { logic [NCH*OW-1:0] data; int due; } exp_t;

  mcfg_t s_cfg[NCH];
  mcfg_t a_cfg[NCH];
  int    acc[NCH];
  bit    m_pend;
  exp_t  sbq[$];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      s_cfg[k] = '{default: 0};
      a_cfg[k] = '{default: 0};
      acc[k]   = 0;
    end
    m_pend = 1'b0;
  endfunction

  // Sample value from the waveform definitions, using plain integer arithmetic
  function automatic int ref_sample(input int k);
    mcfg_t c;
    int p, t, u, w, y, mx;
    c  = a_cfg[k];
    mx = (1 << (AW-1)) - 1;
    if (!c.en) return c.offset;
    p = (acc[k] + c.phase) % (1 << PW);
    t = p >> (PW - AW);
    case (c.mode)
      0:       w = mx;
      1:       w = (p >= (1 << (PW-1))) ? -mx : mx;
      2:       w = t - (1 << (AW-1));
      default: begin
        u = (t < (1 << (AW-1))) ? t : (1 << AW) - 1 - t;
        w = 2*u - mx;
      end
    endcase
    y = c.offset + ((w * c.amp) >>> AW);
    if (y > (1 << (OW-1)) - 1) y = (1 << (OW-1)) - 1;
    if (y < -(1 << (OW-1)))    y = -(1 << (OW-1));
    return y;
  endfunction

  task automatic idle();
    bus.tick = 0; bus.sync = 0; bus.commit = 0; bus.cfg_we = 0;
    bus.cfg_ch = '0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
  endtask

  task automatic step(input bit tk, input bit sy, input bit cm, input bit we,
                      input int ch, input int addr, input logic [31:0] wd);
    bit   exp_err, apply;
    int   o;
    exp_t e;
    bus.tick = tk; bus.sync = sy; bus.commit = cm; bus.cfg_we = we;
    bus.cfg_ch = CW'(ch); bus.cfg_addr = 3'(addr); bus.cfg_wdata = wd;
    exp_err = we && (addr > 4 || ch >= NCH);
    apply   = tk && (cm || m_pend);
    if (apply) for (int k = 0; k < NCH; k++) a_cfg[k] = s_cfg[k];
    if (we && !exp_err) begin
      case (addr)
        0: s_cfg[ch].freq  = int'(wd[PW-1:0]);
        1: s_cfg[ch].phase = int'(wd[PW-1:0]);
        2: s_cfg[ch].amp   = int'(wd[AW-1:0]);
        3: begin
          o = int'(wd[OW-1:0]);
          if (o >= (1 << (OW-1))) o -= (1 << OW);
          s_cfg[ch].offset = o;
        end
        default: begin
          s_cfg[ch].mode = int'(wd[1:0]);
          s_cfg[ch].en   = wd[4];
        end
      endcase
    end
    m_pend = !apply && (cm || m_pend);
    for (int k = 0; k < NCH; k++) begin
      if (sy) acc[k] = 0;
      else if (tk && a_cfg[k].en) acc[k] = (acc[k] + a_cfg[k].freq) % (1 << PW);
    end
    if (tk) begin
      for (int k = 0; k < NCH; k++) e.data[k*OW +: OW] = OW'(ref_sample(k));
      e.due = cyc + 2;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    idle();
    chk("cfg_err", bus.cfg_err, exp_err);
    chk("commit_pend", bus.commit_pend, m_pend);
  endtask

  task automatic wr(input int ch, input int addr, input logic [31:0] wd);
    step(0, 0, 0, 1, ch, addr, wd);
  endtask

  task automatic tk(input int n);
    repeat (n) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_commit_pend", bus.commit_pend, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sample", bus.out_data, e.data);
        chk("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    idle();
    model_reset();
    do_reset();

    // saw ramp on ch0, accumulator wraps after four ticks
    wr(0, 0, 32'h40); wr(0, 2, 32'hFF); wr(0, 4, 32'h12);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("pend_set", bus.commit_pend, 1);
    tk(4);

    // ch1 square saturating high, then low
    wr(1, 4, 32'h11); wr(1, 2, 32'hFF); wr(1, 3, 32'd500);
    step(1, 0, 1, 0, 0, 0, 0);
    tk(1);
    wr(1, 3, 32'hFFFF_FE0C); wr(1, 1, 32'h80);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("pend_set2", bus.commit_pend, 1);
    tk(1);
    chk("pend_clr", bus.commit_pend, 0);
    tk(1);

    // shadow write without commit, then commit+tick in one cycle
    wr(0, 0, 32'h10);
    tk(2);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("pend_same_cycle", bus.commit_pend, 0);
    tk(2);

    // sync+tick: both accumulators restart, phase offset alone sets the level
    wr(0, 1, 32'h80); wr(0, 4, 32'h11); wr(1, 3, 32'h0);
    step(1, 0, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    tk(2);

    // bad addresses are dropped and flagged
    wr(0, 5, 32'h1234);
    chk("err_pulse", bus.cfg_err, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("err_single", bus.cfg_err, 0);
    wr(1, 7, 32'hFFFF_FFFF);
    wr(0, 6, 32'h0);
    step(1, 0, 1, 0, 0, 0, 0);
    tk(2);

    // reset with samples in flight
    tk(2);
    do_reset();
    tk(2);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
             $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4,
             int'($urandom_range(0, NCH-1)), int'($urandom_range(0, 7)), $urandom);
      end
    end

    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    chk("drain", 64'(sbq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
